// File: rtl/mem_arb_pkg.sv
// Shared state/owner types and default tuning constants for the IF/LS memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/arb_prio_starve.sv
// Fixed LS-over-IF priority pick with a saturating count of LS wins taken while IF waits;
// once the count reaches STARVE_MAX the next contested pick goes to IF.
module arb_prio_starve
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic ls_req_i,
    output logic if_win_o,
    output logic ls_win_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_starved;

    assign if_starved = if_req_i && (starve_cnt == CNT_W'(STARVE_MAX));
    assign ls_win_o   = arb_en_i && ls_req_i && !if_starved;
    assign if_win_o   = arb_en_i && if_req_i && !ls_win_o;

    // The count only moves on an actual grant; idle cycles leave it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (if_win_o) begin
            starve_cnt <= '0;
        end else if (ls_win_o && if_req_i && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store with one
// outstanding transaction, LS priority with IF anti-starvation, and a response watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,

    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_err_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W    = DATA_W / 8;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    arb_state_t         state_q, state_d;
    owner_t             owner_q;
    logic [TIMER_W-1:0] timer_q;
    logic               arb_en;
    logic               if_win, ls_win;
    logic               resp_valid, resp_err;

    // Grants are suppressed while reset is held so no gnt escapes during an async reset.
    assign arb_en = (state_q == IDLE) && rst_ni;

    arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .arb_en_i (arb_en),
        .if_req_i (if_req_i),
        .ls_req_i (ls_req_i),
        .if_win_o (if_win),
        .ls_win_o (ls_win)
    );

    assign if_gnt_o = if_win;
    assign ls_gnt_o = ls_win;

    always_comb begin
        state_d    = state_q;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_win || ls_win) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        resp_valid = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The memory request fields are captured at grant so the requester is free to move on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            timer_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (ls_win) begin
                        owner_q     <= OWN_LS;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_we_i;
                        mem_addr_o  <= ls_addr_i;
                        mem_wdata_o <= ls_wdata_i;
                        mem_be_o    <= ls_be_i;
                    end else if (if_win) begin
                        owner_q     <= OWN_IF;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        mem_be_o    <= {BE_W{1'b1}};
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        timer_q   <= '0;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                end
                default: begin
                    timer_q <= '0;
                end
            endcase
        end
    end

    // A timed-out response carries zero data; a late rvalid in IDLE never reaches a port.
    assign if_rvalid_o = resp_valid && (owner_q == OWN_IF);
    assign ls_rvalid_o = resp_valid && (owner_q == OWN_LS);
    assign if_err_o    = resp_err && (owner_q == OWN_IF);
    assign ls_err_o    = resp_err && (owner_q == OWN_LS);
    assign if_rdata_o  = (if_rvalid_o && !resp_err) ? mem_rdata_i : '0;
    assign ls_rdata_o  = (ls_rvalid_o && !resp_err) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i, ls_we_i;
    logic [31:0] ls_addr_i, ls_wdata_i;
    logic [3:0]  ls_be_i;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .if_err_o     (if_err_o),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_be_i      (ls_be_i),
        .ls_gnt_o     (ls_gnt_o),
        .ls_rvalid_o  (ls_rvalid_o),
        .ls_rdata_o   (ls_rdata_o),
        .ls_err_o     (ls_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_be;
        logic        exp_if_gnt;
        logic        exp_ls_gnt;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lsr,
                                 input logic lswe, input logic [31:0] lsa, input logic [31:0] lswd,
                                 input logic [3:0] lsbe, input logic mg, input logic mrv,
                                 input logic [31:0] mrd);
        @(negedge clk_i);
        if_req_i     = ifr;
        if_addr_i    = ifa;
        ls_req_i     = lsr;
        ls_we_i      = lswe;
        ls_addr_i    = lsa;
        ls_wdata_i   = lswd;
        ls_be_i      = lsbe;
        mem_gnt_i    = mg;
        mem_rvalid_i = mrv;
        mem_rdata_i  = mrd;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model state: a transaction is either absent, waiting for memory accept,
    // or accepted and counting WAIT cycles.
    bit          m_busy, m_accepted, m_own_ls, m_silent;
    int          m_wait_n, m_streak;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    initial begin
        bit          exp_ls_order [6];
        int          n_wait;
        bit          got;
        logic        r_if, r_ls, r_we, r_gnt, r_rv;
        logic [31:0] r_ifa, r_lsa, r_wd, r_rd;
        logic [3:0]  r_be;
        bit          ls_pick, if_pick, deliver, err;
        logic [31:0] exp_rd;

        vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h300, 32'h1234,     4'hF, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h1234};
        vecs[2] = '{1'b1, 32'h180, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 32'h200, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'h180, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h180, 32'h0};
        vecs[4] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0};
        exp_ls_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset with both requesters active: nothing may be granted or driven.
        rst_ni = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h40; ls_req_i = 1'b1; ls_we_i = 1'b1;
        ls_addr_i = 32'h80; ls_wdata_i = 32'hFFFF; ls_be_i = 4'hF;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111;
        #3;
        checkOutput("rst_if_gnt", if_gnt_o, 0);
        checkOutput("rst_ls_gnt", ls_gnt_o, 0);
        checkOutput("rst_mem_req", mem_req_o, 0);
        checkOutput("rst_mem_we", mem_we_o, 0);
        checkOutput("rst_mem_addr", mem_addr_o, 0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 0);
        checkOutput("rst_mem_be", mem_be_o, 0);
        checkOutput("rst_rvalid", {if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o}, 0);
        checkOutput("rst_rdata", {if_rdata_o, ls_rdata_o}, 0);
        repeat (2) @(negedge clk_i);
        if_req_i = 0; ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        rst_ni = 1'b1;

        // IF-only fetch: memory accepts one cycle late, data two cycles after accept.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("if1_gnt", if_gnt_o, 1);
        checkOutput("if1_ls_gnt", ls_gnt_o, 0);
        applyIdle();
        checkOutput("if1_req", mem_req_o, 1);
        checkOutput("if1_addr", mem_addr_o, 32'h100);
        checkOutput("if1_we", mem_we_o, 0);
        checkOutput("if1_be", mem_be_o, 4'hF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("if1_req_held", mem_req_o, 1);
        applyIdle();
        checkOutput("if1_req_dropped", mem_req_o, 0);
        checkOutput("if1_no_early_rvalid", if_rvalid_o, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13);
        checkOutput("if1_rvalid", if_rvalid_o, 1);
        checkOutput("if1_rdata", if_rdata_o, 32'h13);
        checkOutput("if1_err", if_err_o, 0);
        checkOutput("if1_ls_rvalid", ls_rvalid_o, 0);
        checkOutput("if1_ls_rdata", ls_rdata_o, 0);
        applyIdle();
        checkOutput("if1_rvalid_single", if_rvalid_o, 0);

        // Vector table: each grant is answered with accept+data in the ISSUE cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_we,
                          vecs[i].ls_addr, vecs[i].ls_wdata, vecs[i].ls_be, 0, 0, 0);
            checkOutput($sformatf("v%0d_if_gnt", i), if_gnt_o, vecs[i].exp_if_gnt);
            checkOutput($sformatf("v%0d_ls_gnt", i), ls_gnt_o, vecs[i].exp_ls_gnt);
            if (vecs[i].exp_if_gnt || vecs[i].exp_ls_gnt) begin
                applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA500_0000 + i);
                checkOutput($sformatf("v%0d_mem_req", i), mem_req_o, 1);
                checkOutput($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].exp_addr);
                checkOutput($sformatf("v%0d_mem_we", i), mem_we_o, vecs[i].exp_we);
                checkOutput($sformatf("v%0d_mem_be", i), mem_be_o, vecs[i].exp_be);
                checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].exp_wdata);
                checkOutput($sformatf("v%0d_if_rvalid", i), if_rvalid_o, vecs[i].exp_if_gnt);
                checkOutput($sformatf("v%0d_ls_rvalid", i), ls_rvalid_o, vecs[i].exp_ls_gnt);
                checkOutput($sformatf("v%0d_rdata", i), vecs[i].exp_ls_gnt ? ls_rdata_o : if_rdata_o,
                            32'hA500_0000 + i);
                applyIdle();
                checkOutput($sformatf("v%0d_idle_rvalid", i), {if_rvalid_o, ls_rvalid_o}, 0);
            end
        end

        // Both held with instant memory: grants every other cycle, IF forced after 4 LS wins.
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1, 32'h400, 1, 0, 32'h500, 0, 4'hF, 1, 1, 32'h77);
            if (c % 2 == 0) begin
                checkOutput($sformatf("starve_ls_gnt%0d", c / 2), ls_gnt_o, exp_ls_order[c / 2]);
                checkOutput($sformatf("starve_if_gnt%0d", c / 2), if_gnt_o, !exp_ls_order[c / 2]);
            end else begin
                checkOutput($sformatf("starve_nognt%0d", c), {if_gnt_o, ls_gnt_o}, 0);
            end
        end
        applyIdle();

        // Watchdog: memory accepts but never answers.
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("to_if_gnt", if_gnt_o, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_wait = 0;
        got = 0;
        while (!got && n_wait < 100) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
            n_wait++;
            if (if_rvalid_o) got = 1;
        end
        checkOutput("to_wait_cycles", n_wait, TIMEOUT);
        checkOutput("to_if_err", if_err_o, 1);
        checkOutput("to_if_rdata", if_rdata_o, 0);
        checkOutput("to_ls_rvalid", ls_rvalid_o, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD);
            checkOutput($sformatf("to_stray_rvalid%0d", k), {if_rvalid_o, ls_rvalid_o}, 0);
        end

        // Reset asserted mid-WAIT: outputs clear immediately, nothing delivered afterwards.
        applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyIdle();
        checkOutput("rw_addr_before", mem_addr_o, 32'h700);
        rst_ni = 1'b0;
        mem_rvalid_i = 1'b1;
        #1;
        checkOutput("rw_mem_addr", mem_addr_o, 0);
        checkOutput("rw_mem_be", mem_be_o, 0);
        checkOutput("rw_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
        checkOutput("rw_post_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        applyStimulus(1, 32'h704, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rw_fresh_gnt", if_gnt_o, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h55);
        checkOutput("rw_fresh_addr", mem_addr_o, 32'h704);
        checkOutput("rw_fresh_rvalid", if_rvalid_o, 1);
        checkOutput("rw_fresh_rdata", if_rdata_o, 32'h55);
        applyIdle();

        // Randomized traffic against the reference model, from a fresh reset.
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        m_busy = 0; m_accepted = 0; m_streak = 0; m_wait_n = 0; m_silent = 0; m_own_ls = 0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_if  = 1'($urandom_range(0, 1));
            r_ls  = 1'($urandom_range(0, 1));
            r_we  = 1'($urandom_range(0, 1));
            r_ifa = $urandom;
            r_lsa = $urandom;
            r_wd  = $urandom;
            r_be  = 4'($urandom_range(0, 15));
            r_gnt = 1'($urandom_range(0, 1));
            r_rv  = ($urandom_range(0, 3) == 0);
            r_rd  = $urandom;
            if (m_busy && m_silent) r_rv = 1'b0;
            applyStimulus(r_if, r_ifa, r_ls, r_we, r_lsa, r_wd, r_be, r_gnt, r_rv, r_rd);

            ls_pick = 0; if_pick = 0; deliver = 0; err = 0;
            if (!m_busy) begin
                ls_pick = r_ls && !(r_if && m_streak == STARVE_MAX);
                if_pick = r_if && !ls_pick;
            end else if (!m_accepted) begin
                deliver = r_gnt && r_rv;
            end else begin
                m_wait_n++;
                if (r_rv) deliver = 1;
                else if (m_wait_n == TIMEOUT) begin deliver = 1; err = 1; end
            end
            exp_rd = (deliver && !err) ? r_rd : 32'h0;

            checkOutput("rnd_if_gnt", if_gnt_o, if_pick);
            checkOutput("rnd_ls_gnt", ls_gnt_o, ls_pick);
            checkOutput("rnd_if_rvalid", if_rvalid_o, deliver && !m_own_ls);
            checkOutput("rnd_ls_rvalid", ls_rvalid_o, deliver && m_own_ls);
            checkOutput("rnd_if_err", if_err_o, err && !m_own_ls);
            checkOutput("rnd_ls_err", ls_err_o, err && m_own_ls);
            checkOutput("rnd_if_rdata", if_rdata_o, m_own_ls ? 32'h0 : exp_rd);
            checkOutput("rnd_ls_rdata", ls_rdata_o, m_own_ls ? exp_rd : 32'h0);
            checkOutput("rnd_mem_req", mem_req_o, m_busy && !m_accepted);
            if (m_busy && !m_accepted) begin
                checkOutput("rnd_mem_fields", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o},
                            {m_we, m_be, m_addr, m_wdata});
            end

            if (!m_busy) begin
                if (ls_pick) begin
                    m_own_ls = 1; m_we = r_we; m_addr = r_lsa; m_wdata = r_wd; m_be = r_be;
                    if (r_if && m_streak < STARVE_MAX) m_streak++;
                end else if (if_pick) begin
                    m_own_ls = 0; m_we = 0; m_addr = r_ifa; m_wdata = 0; m_be = 4'hF;
                    m_streak = 0;
                end
                if (ls_pick || if_pick) begin
                    m_busy = 1;
                    m_accepted = 0;
                    m_silent = ($urandom_range(0, 15) == 0);
                end
            end else if (!m_accepted) begin
                if (deliver) m_busy = 0;
                else if (r_gnt) begin m_accepted = 1; m_wait_n = 0; end
            end else if (deliver) begin
                m_busy = 0;
                m_accepted = 0;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
